// File: rtl/uart_tx_feeder_pkg.sv
// uart_pkg: shared state encoding for the UART transmit feeder
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3} state_t;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: host write port (wr_data/wr_en/full/empty/count/overflow) and transmitter port (p_data/data_valid/busy)
interface uart_tx_feeder_if #(parameter int DATA_WIDTH = 8, parameter int DEPTH = 16);
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_en;
  logic full;
  logic empty;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic [DATA_WIDTH-1:0] p_data;
  logic data_valid;
  logic busy;
  modport master (output wr_data, wr_en, busy, input full, empty, count, overflow, p_data, data_valid);
  modport slave (input wr_data, wr_en, busy, output full, empty, count, overflow, p_data, data_valid);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: DEPTH-word FIFO; in clk/rst/push/pop/wr_data, out rd_data/count/full/empty/overflow (registered drop pulse)
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      overflow <= push && full;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host words and offers them to the UART transmitter; ports clk, rst and bus (slave: host write side plus p_data/data_valid/busy)
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input logic clk,
  input logic rst,
  uart_tx_feeder_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic pop;
  logic [DATA_WIDTH-1:0] rd_data;
  uart_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.wr_en),
    .pop(pop),
    .wr_data(bus.wr_data),
    .rd_data(rd_data),
    .count(bus.count),
    .full(bus.full),
    .empty(bus.empty),
    .overflow(bus.overflow)
  );
  // WAIT_BUSY spends ACK_TIMEOUT cycles, so offers repeat every ACK_TIMEOUT+1 cycles
  always_comb begin
    state_n = state;
    tcnt_n = tcnt;
    pop = 1'b0;
    unique case (state)
      IDLE: if (!bus.empty && !bus.busy) begin
        state_n = LOAD;
        pop = 1'b1;
        tcnt_n = '0;
      end
      LOAD: begin
        state_n = WAIT_BUSY;
        tcnt_n = '0;
      end
      WAIT_BUSY: if (bus.busy) state_n = WAIT_DONE;
      else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
        state_n = LOAD;
        tcnt_n = '0;
      end else tcnt_n = tcnt + 1'b1;
      WAIT_DONE: state_n = bus.busy ? WAIT_DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      bus.p_data <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      bus.data_valid <= state_n == LOAD;
      if (pop) bus.p_data <= rd_data;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized self-checking bench with a behavioural transmitter model
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_feeder_if #(.DATA_WIDTH(8), .DEPTH(16)) bus();
  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(16), .ACK_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic auto_ack = 1'b0;
  logic manual_busy = 1'b0;
  logic model_busy = 1'b0;
  int fixed_len = 0;
  assign bus.busy = auto_ack ? model_busy : manual_busy;
  int pulse_t[$];
  logic [7:0] pulse_d[$];
  logic [7:0] rx_q[$];
  int stab_err = 0, gap_err = 0;
  int ack_at = -1, drop_at = 0, last_fall = -100;
  logic [7:0] held = 8'h00;
  int checks = 0, errors = 0;

  // transmitter model: acks an offer one cycle later, holds busy for a frame, logs accepted words
  always @(negedge clk) begin
    if (rst) begin
      model_busy = 1'b0;
      ack_at = -1;
    end else begin
      if (bus.data_valid) begin
        pulse_t.push_back(cyc);
        pulse_d.push_back(bus.p_data);
        if (cyc - last_fall < 2) gap_err++;
        if (auto_ack && !model_busy) ack_at = cyc + 1;
      end
      if (model_busy) begin
        if (bus.p_data !== held) stab_err++;
        if (cyc == drop_at) begin
          model_busy = 1'b0;
          last_fall = cyc;
        end
      end else if (auto_ack && cyc == ack_at) begin
        model_busy = 1'b1;
        held = bus.p_data;
        rx_q.push_back(held);
        drop_at = cyc + (fixed_len > 0 ? fixed_len : int'($urandom_range(1, 6)));
        ack_at = -1;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
  endtask

  task automatic stop_wr();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks += 4;
      if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty cyc=%0d got=%b exp=1", cyc, bus.empty); end
      if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", cyc, bus.count); end
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv cyc=%0d got=%b exp=0", cyc, bus.data_valid); end
      if (bus.p_data !== 8'h00) begin errors++; $display("FAIL reset_pdata cyc=%0d got=%h exp=00", cyc, bus.p_data); end
    end
  endtask

  task automatic test_single();
    int p0, r0, s0, n;
    p0 = pulse_t.size(); r0 = rx_q.size(); s0 = stab_err;
    fixed_len = 10; auto_ack = 1'b1;
    push(8'hA5); stop_wr(); n = cyc;
    repeat (25) @(negedge clk);
    checks++;
    if (pulse_t.size() != p0 + 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulse_t.size() - p0); end
    else begin
      checks += 2;
      if (pulse_t[p0] != n + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", pulse_t[p0], n + 1); end
      if (pulse_d[p0] !== 8'hA5) begin errors++; $display("FAIL single_pdata got=%h exp=a5", pulse_d[p0]); end
    end
    checks++;
    if (rx_q.size() != r0 + 1 || rx_q[rx_q.size() - 1] !== 8'hA5) begin errors++; $display("FAIL single_rx got_n=%0d exp_n=1", rx_q.size() - r0); end
    checks += 3;
    if (stab_err != s0) begin errors++; $display("FAIL single_stable got=%0d exp=0 glitches", stab_err - s0); end
    if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count got=%0d exp=0", bus.count); end
    if (bus.p_data !== 8'hA5) begin errors++; $display("FAIL single_hold got=%h exp=a5", bus.p_data); end
    fixed_len = 0;
  endtask

  task automatic test_burst_overflow();
    int p0, r0, g0, s0, w;
    auto_ack = 1'b0; manual_busy = 1'b1;
    p0 = pulse_t.size(); r0 = rx_q.size(); g0 = gap_err; s0 = stab_err;
    for (int i = 1; i <= 16; i++) push(8'(i));
    stop_wr();
    checks += 3;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL burst_full got=%b exp=1", bus.full); end
    if (bus.count !== 5'd16) begin errors++; $display("FAIL burst_count got=%0d exp=16", bus.count); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst_noovf got=%b exp=0", bus.overflow); end
    push(8'h11); stop_wr();
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf got=%b exp=1", bus.overflow); end
    if (bus.count !== 5'd16) begin errors++; $display("FAIL burst_ovf_count got=%0d exp=16", bus.count); end
    @(negedge clk);
    checks += 2;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_pulse got=%b exp=0", bus.overflow); end
    if (pulse_t.size() != p0) begin errors++; $display("FAIL burst_foreign got=%0d exp=0 offers", pulse_t.size() - p0); end
    manual_busy = 1'b0; auto_ack = 1'b1;
    w = 0;
    while (rx_q.size() < r0 + 16 && w < 400) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    checks++;
    if (rx_q.size() != r0 + 16) begin errors++; $display("FAIL burst_rx_n got=%0d exp=16", rx_q.size() - r0); end
    else for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_q[r0 + i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order idx=%0d got=%h exp=%h", i, rx_q[r0 + i], 8'(i + 1)); end
    end
    checks += 4;
    if (pulse_t.size() != p0 + 16) begin errors++; $display("FAIL burst_pulses got=%0d exp=16", pulse_t.size() - p0); end
    if (gap_err != g0) begin errors++; $display("FAIL burst_gap got=%0d exp=0", gap_err - g0); end
    if (stab_err != s0) begin errors++; $display("FAIL burst_stable got=%0d exp=0", stab_err - s0); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL burst_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_reoffer();
    int p0, r0, t, w, cbad;
    auto_ack = 1'b0; manual_busy = 1'b0;
    p0 = pulse_t.size(); r0 = rx_q.size(); cbad = 0;
    push(8'h3C); push(8'h5A); stop_wr();
    w = 0;
    while (pulse_t.size() <= p0 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (pulse_t.size() <= p0) begin errors++; $display("FAIL reoffer_first got=0 exp=1 offers"); return; end
    t = pulse_t[p0];
    while (cyc < t + 12) begin
      @(negedge clk);
      if (bus.count !== 5'd1) cbad++;
    end
    manual_busy = 1'b1;
    checks += 2;
    if (cbad != 0) begin errors++; $display("FAIL reoffer_count got=%0d bad cycles exp=0", cbad); end
    if (pulse_t.size() != p0 + 3) begin errors++; $display("FAIL reoffer_n got=%0d exp=3", pulse_t.size() - p0); end
    else for (int i = 1; i < 3; i++) begin
      checks += 2;
      if (pulse_t[p0 + i] != t + 5 * i) begin errors++; $display("FAIL reoffer_time idx=%0d got=%0d exp=%0d", i, pulse_t[p0 + i], t + 5 * i); end
      if (pulse_d[p0 + i] !== 8'h3C) begin errors++; $display("FAIL reoffer_data idx=%0d got=%h exp=3c", i, pulse_d[p0 + i]); end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pulse_t.size() != p0 + 3) begin errors++; $display("FAIL reoffer_after_busy got=%0d exp=3", pulse_t.size() - p0); end
    manual_busy = 1'b0; auto_ack = 1'b1;
    w = 0;
    while (rx_q.size() <= r0 && w < 40) begin @(negedge clk); w++; end
    repeat (12) @(negedge clk);
    checks += 2;
    if (rx_q.size() != r0 + 1 || rx_q[rx_q.size() - 1] !== 8'h5A) begin errors++; $display("FAIL reoffer_next got_n=%0d exp_n=1 word 5a", rx_q.size() - r0); end
    if (bus.count !== 5'd0) begin errors++; $display("FAIL reoffer_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int r0, w, g0, s0;
    auto_ack = 1'b0; manual_busy = 1'b1;
    r0 = rx_q.size(); g0 = gap_err; s0 = stab_err;
    for (int i = 0; i < 5; i++) begin d = 8'($urandom); exp_q.push_back(d); push(d); end
    stop_wr();
    checks++;
    if (bus.count !== 5'd5) begin errors++; $display("FAIL wrap_pre_count got=%0d exp=5", bus.count); end
    d = 8'($urandom); exp_q.push_back(d);
    manual_busy = 1'b0;
    push(d); stop_wr();
    checks += 2;
    if (bus.count !== 5'd5) begin errors++; $display("FAIL wrap_simul_count got=%0d exp=5", bus.count); end
    if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL wrap_simul_dv got=%b exp=1", bus.data_valid); end
    @(negedge clk);
    auto_ack = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 8; k++) begin d = 8'($urandom); exp_q.push_back(d); push(d); end
      stop_wr();
      w = 0;
      while (rx_q.size() < r0 + exp_q.size() && w < 1000) begin @(negedge clk); w++; end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rx_q.size() != r0 + exp_q.size()) begin errors++; $display("FAIL wrap_rx_n got=%0d exp=%0d", rx_q.size() - r0, exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (rx_q[r0 + i] !== exp_q[i]) begin errors++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, rx_q[r0 + i], exp_q[i]); end
    end
    checks += 2;
    if (gap_err != g0) begin errors++; $display("FAIL wrap_gap got=%0d exp=0", gap_err - g0); end
    if (stab_err != s0) begin errors++; $display("FAIL wrap_stable got=%0d exp=0", stab_err - s0); end
  endtask

  task automatic test_reset_mid();
    int r0, p1, w;
    auto_ack = 1'b1; fixed_len = 30;
    r0 = rx_q.size();
    for (int i = 0; i < 4; i++) push(8'($urandom_range(1, 255)));
    stop_wr();
    w = 0;
    while (rx_q.size() <= r0 && w < 20) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.count !== 5'd3) begin errors++; $display("FAIL rstmid_pre_count got=%0d exp=3", bus.count); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", bus.empty); end
    if (bus.count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
    if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dv got=%b exp=0", bus.data_valid); end
    if (bus.p_data !== 8'h00) begin errors++; $display("FAIL rstmid_pdata got=%h exp=00", bus.p_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0; fixed_len = 0;
    p1 = pulse_t.size();
    repeat (20) @(negedge clk);
    checks++;
    if (pulse_t.size() != p1) begin errors++; $display("FAIL rstmid_quiet got=%0d exp=0 offers", pulse_t.size() - p1); end
    r0 = rx_q.size();
    push(8'hC3); stop_wr();
    w = 0;
    while (rx_q.size() <= r0 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (rx_q.size() != r0 + 1 || rx_q[rx_q.size() - 1] !== 8'hC3) begin errors++; $display("FAIL rstmid_new got_n=%0d exp_n=1 word c3", rx_q.size() - r0); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst_overflow();
    test_reoffer();
    test_wrap();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
